wb_regfile_unit: RTL and testbench

- Consumer end of the MEM/WB pipeline register: the writeback stage plus the architectural integer register file.
- Takes the registered writeback bundle (wb_*), applies RISC-V load extraction and extension, and selects load data or the ALU result.
- Commits the selected value to a 32x32 register file (x0 hardwired to zero) and serves two decode-stage read ports.
- Keeps a 64-bit retired-writeback counter for debug/perf.

---
 rtl/wb_regfile_unit.sv | 117 +++++++++++
 tb/tb_wb_regfile_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_unit.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_unit
// Brief    : Writeback stage (load extract/extend + mux), 32x32 regfile with
//            x0 hardwired to zero, two async read ports, 64-bit retire counter.
//            Optional macro WB_BYPASS_EN enables write-through read bypass.
// Revision : 1.0
// ============================================================================
module wb_regfile_unit #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [XLEN-1:0]         wb_mem_data,
  input  logic [XLEN-1:0]         wb_alu_o,
  input  logic [$clog2(NREG)-1:0] wb_rd,
  input  logic                    wb_mem2reg,
  input  logic                    wb_regs_write,
  input  logic [2:0]              wb_func3_code,
  input  logic [$clog2(NREG)-1:0] id_rs1,
  input  logic [$clog2(NREG)-1:0] id_rs2,
  output logic [XLEN-1:0]         id_rs1_data,
  output logic [XLEN-1:0]         id_rs2_data,
  output logic [XLEN-1:0]         wb_wdata,
  output logic                    wb_we,
  output logic [CNT_W-1:0]        instret
);

  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;

  logic [XLEN-1:0]  r_regs [0:NREG-1];
  logic [CNT_W-1:0] r_instret;

  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [XLEN-1:0]  w_load;
  logic [XLEN-1:0]  w_wdata;
  logic             w_we;
  logic [XLEN-1:0]  w_rs1_data;
  logic [XLEN-1:0]  w_rs2_data;

  // Memory word is already aligned; the low address bits pick the lane.
  always_comb begin
    w_byte = '0;
    case (wb_alu_o[1:0])
      2'd0:    w_byte = wb_mem_data[7:0];
      2'd1:    w_byte = wb_mem_data[15:8];
      2'd2:    w_byte = wb_mem_data[23:16];
      default: w_byte = wb_mem_data[31:24];
    endcase
    w_half = wb_alu_o[1] ? wb_mem_data[31:16] : wb_mem_data[15:0];

    w_load = '0;
    case (wb_func3_code)
      c_F3_LB:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      c_F3_LH:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
      c_F3_LW:  w_load = wb_mem_data;
      c_F3_LBU: w_load = {{(XLEN-8){1'b0}}, w_byte};
      c_F3_LHU: w_load = {{(XLEN-16){1'b0}}, w_half};
      default:  w_load = '0;
    endcase
  end

  assign w_wdata = wb_mem2reg ? w_load : wb_alu_o;
  assign w_we    = wb_regs_write && (wb_rd != '0) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_instret <= '0;
    end else if (w_we) begin
      r_regs[wb_rd] <= w_wdata;
      r_instret     <= r_instret + 1'b1;
    end
  end

  // Entry 0 is never written; reads of index 0 are forced to zero anyway.
  always_comb begin
    w_rs1_data = '0;
    if (!rst && id_rs1 != '0) begin
`ifdef WB_BYPASS_EN
      if (w_we && id_rs1 == wb_rd) w_rs1_data = w_wdata;
      else                         w_rs1_data = r_regs[id_rs1];
`else
      w_rs1_data = r_regs[id_rs1];
`endif
    end
  end

  always_comb begin
    w_rs2_data = '0;
    if (!rst && id_rs2 != '0) begin
`ifdef WB_BYPASS_EN
      if (w_we && id_rs2 == wb_rd) w_rs2_data = w_wdata;
      else                         w_rs2_data = r_regs[id_rs2];
`else
      w_rs2_data = r_regs[id_rs2];
`endif
    end
  end

  assign id_rs1_data = w_rs1_data;
  assign id_rs2_data = w_rs2_data;
  assign wb_wdata    = w_wdata;
  assign wb_we       = w_we;
  assign instret     = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile_unit
// Brief    : Directed self-checking bench for wb_regfile_unit.
// Revision : 1.0
// ============================================================================
module tb_wb_regfile_unit;

  logic        clk;
  logic        rst;
  logic [31:0] wb_mem_data;
  logic [31:0] wb_alu_o;
  logic [4:0]  wb_rd;
  logic        wb_mem2reg;
  logic        wb_regs_write;
  logic [2:0]  wb_func3_code;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic [63:0] instret;

  int n_vec = 0;
  int n_err = 0;

  wb_regfile_unit u_dut (
    .clk           (clk),
    .rst           (rst),
    .wb_mem_data   (wb_mem_data),
    .wb_alu_o      (wb_alu_o),
    .wb_rd         (wb_rd),
    .wb_mem2reg    (wb_mem2reg),
    .wb_regs_write (wb_regs_write),
    .wb_func3_code (wb_func3_code),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rs1_data   (id_rs1_data),
    .id_rs2_data   (id_rs2_data),
    .wb_wdata      (wb_wdata),
    .wb_we         (wb_we),
    .instret       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load table: func3, byte offset, destination, expected extended value
  logic [2:0]  lt_f3  [8];
  logic [1:0]  lt_off [8];
  logic [4:0]  lt_rd  [8];
  logic [31:0] lt_exp [8];

  initial begin
    lt_f3[0] = 3'b000; lt_off[0] = 2'd0; lt_rd[0] = 5'd10; lt_exp[0] = 32'hFFFF_FF82;
    lt_f3[1] = 3'b100; lt_off[1] = 2'd1; lt_rd[1] = 5'd11; lt_exp[1] = 32'h0000_007F;
    lt_f3[2] = 3'b001; lt_off[2] = 2'd2; lt_rd[2] = 5'd12; lt_exp[2] = 32'hFFFF_80F1;
    lt_f3[3] = 3'b101; lt_off[3] = 2'd2; lt_rd[3] = 5'd13; lt_exp[3] = 32'h0000_80F1;
    lt_f3[4] = 3'b010; lt_off[4] = 2'd0; lt_rd[4] = 5'd14; lt_exp[4] = 32'h80F1_7F82;
    lt_f3[5] = 3'b000; lt_off[5] = 2'd3; lt_rd[5] = 5'd15; lt_exp[5] = 32'hFFFF_FF80;
    lt_f3[6] = 3'b001; lt_off[6] = 2'd1; lt_rd[6] = 5'd16; lt_exp[6] = 32'h0000_7F82;
    lt_f3[7] = 3'b010; lt_off[7] = 2'd3; lt_rd[7] = 5'd17; lt_exp[7] = 32'h80F1_7F82;

    // Reset with a write pending: it must be discarded
    rst = 1'b1; wb_regs_write = 1'b1; wb_rd = 5'd5; wb_alu_o = 32'h55;
    wb_mem2reg = 1'b0; wb_mem_data = 32'h0; wb_func3_code = 3'b010;
    id_rs1 = 5'd5; id_rs2 = 5'd31;
    #1;
    chk("rst_we", {63'd0, wb_we}, 64'd0);
    chk("rst_rs1", {32'd0, id_rs1_data}, 64'd0);
    tick(); tick();
    rst = 1'b0; wb_regs_write = 1'b0;
    #1;
    chk("post_rst_rs1", {32'd0, id_rs1_data}, 64'd0);
    chk("post_rst_rs2", {32'd0, id_rs2_data}, 64'd0);
    chk("post_rst_instret", instret, 64'd0);

    // ALU writeback
    wb_mem2reg = 1'b0; wb_alu_o = 32'hDEAD_BEEF; wb_rd = 5'd3; wb_regs_write = 1'b1;
    #1;
    chk("alu_wdata", {32'd0, wb_wdata}, 64'h0000_0000_DEAD_BEEF);
    chk("alu_we", {63'd0, wb_we}, 64'd1);
    tick();
    wb_regs_write = 1'b0; id_rs1 = 5'd3;
    #1;
    chk("alu_readback", {32'd0, id_rs1_data}, 64'h0000_0000_DEAD_BEEF);
    chk("alu_instret", instret, 64'd1);

    // Load extraction and extension
    wb_mem_data = 32'h80F1_7F82; wb_mem2reg = 1'b1; wb_regs_write = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wb_func3_code = lt_f3[i];
      wb_alu_o = {30'h0000_0400, lt_off[i]};
      wb_rd = lt_rd[i];
      #1;
      chk($sformatf("load_wdata_%0d", i), {32'd0, wb_wdata}, {32'd0, lt_exp[i]});
      tick();
    end
    wb_regs_write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      id_rs1 = lt_rd[i];
      #1;
      chk($sformatf("load_readback_x%0d", lt_rd[i]), {32'd0, id_rs1_data}, {32'd0, lt_exp[i]});
    end
    chk("load_instret", instret, 64'd9);

    // Write to x0 is dropped and not counted
    wb_mem2reg = 1'b0; wb_alu_o = 32'h1234; wb_rd = 5'd0; wb_regs_write = 1'b1; id_rs1 = 5'd0;
    #1;
    chk("x0_we", {63'd0, wb_we}, 64'd0);
    tick();
    wb_regs_write = 1'b0;
    #1;
    chk("x0_read", {32'd0, id_rs1_data}, 64'd0);
    chk("x0_instret", instret, 64'd9);

    // Same-cycle collision
    wb_alu_o = 32'h11; wb_rd = 5'd7; wb_regs_write = 1'b1;
    tick();
    wb_alu_o = 32'h22; id_rs1 = 5'd7; id_rs2 = 5'd7;
    #1;
`ifdef WB_BYPASS_EN
    chk("collide_rs2", {32'd0, id_rs2_data}, 64'h22);
`else
    chk("collide_rs2", {32'd0, id_rs2_data}, 64'h11);
`endif
    tick();
    wb_regs_write = 1'b0;
    #1;
    chk("collide_after_rs1", {32'd0, id_rs1_data}, 64'h22);
    chk("collide_after_rs2", {32'd0, id_rs2_data}, 64'h22);
    chk("collide_instret", instret, 64'd11);

    // Illegal func3 writes zero over a previously nonzero register
    wb_alu_o = 32'h77; wb_rd = 5'd9; wb_regs_write = 1'b1; wb_mem2reg = 1'b0;
    tick();
    wb_mem2reg = 1'b1; wb_alu_o = 32'h0; wb_func3_code = 3'b110;
    #1;
    chk("illegal_110", {32'd0, wb_wdata}, 64'd0);
    wb_func3_code = 3'b111;
    #1;
    chk("illegal_111", {32'd0, wb_wdata}, 64'd0);
    wb_func3_code = 3'b011;
    #1;
    chk("illegal_011", {32'd0, wb_wdata}, 64'd0);
    tick();
    wb_regs_write = 1'b0; id_rs1 = 5'd9;
    #1;
    chk("illegal_x9", {32'd0, id_rs1_data}, 64'd0);
    chk("illegal_instret", instret, 64'd13);

    // Reset dominates a simultaneous write
    rst = 1'b1; wb_mem2reg = 1'b0; wb_alu_o = 32'h55; wb_rd = 5'd9; wb_regs_write = 1'b1;
    tick();
    rst = 1'b0; wb_regs_write = 1'b0; id_rs1 = 5'd9; id_rs2 = 5'd3;
    #1;
    chk("rstpri_x9", {32'd0, id_rs1_data}, 64'd0);
    chk("rstpri_x3_cleared", {32'd0, id_rs2_data}, 64'd0);
    chk("rstpri_instret", instret, 64'd0);

    // No warm-up after reset
    wb_alu_o = 32'hA5; wb_rd = 5'd4; wb_regs_write = 1'b1;
    tick();
    wb_regs_write = 1'b0; id_rs1 = 5'd4;
    #1;
    chk("warm_x4", {32'd0, id_rs1_data}, 64'hA5);
    chk("warm_instret", instret, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
